// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter, one byte per grant.
// Define UART_ARB_TIMEOUT_EN to add a completion watchdog with abort and err_timeout pulse.
module uart_tx_arbiter #(
`ifdef UART_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 131072,
`endif
  parameter int NUM_REQ = 4,
  parameter int TRIG_CYCLES = 4,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_parity,
  input  logic [NUM_REQ-1:0]   req_stop2,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic                 tx_trigger,
  output logic [7:0]           tx_data,
  output logic                 tx_parity_en,
  output logic                 tx_stop2,
  input  logic                 tx_sended,
  output logic                 err_timeout
);
  localparam int TW = $clog2(TRIG_CYCLES + 1);
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_CLR, S_WAIT_DONE, S_ACK} state_t;
  state_t r_state, w_next;
  logic r_s1, r_sd, r_par, r_stop2, w_any, w_to;
  logic [GW-1:0] r_ptr, r_gid, w_pick;
  logic [7:0] r_data;
  logic [TW-1:0] r_tcnt;
  // lowest offset from the pointer wins, so scan offsets from the top down
  always_comb begin
    int j;
    j = 0;
    w_pick = '0;
    w_any = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) w_pick = GW'(j);
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = w_any ? S_TRIG : S_IDLE;
      S_TRIG:      w_next = r_tcnt == TW'(TRIG_CYCLES - 1) ? S_WAIT_CLR : S_TRIG;
      S_WAIT_CLR:  w_next = w_to ? S_ACK : !r_sd ? S_WAIT_DONE : S_WAIT_CLR;
      S_WAIT_DONE: w_next = (w_to || r_sd) ? S_ACK : S_WAIT_DONE;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_s1 <= 1'b0;
      r_sd <= 1'b0;
      r_tcnt <= '0;
      r_ptr <= '0;
      r_gid <= '0;
      r_data <= '0;
      r_par <= 1'b0;
      r_stop2 <= 1'b0;
    end else begin
      r_state <= w_next;
      r_s1 <= tx_sended;
      r_sd <= r_s1;
      r_tcnt <= r_state == S_TRIG ? r_tcnt + 1'b1 : '0;
      if (r_state == S_IDLE && w_any) begin
        r_gid <= w_pick;
        r_data <= req_data[8*w_pick +: 8];
        r_par <= req_parity[w_pick];
        r_stop2 <= req_stop2[w_pick];
      end
      if (r_state == S_ACK) r_ptr <= r_gid == GW'(NUM_REQ - 1) ? '0 : r_gid + 1'b1;
    end
  end
`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] r_wcnt;
  logic r_to;
  assign w_to = (r_state == S_WAIT_CLR || r_state == S_WAIT_DONE) && r_wcnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt <= '0;
      r_to <= 1'b0;
    end else begin
      r_wcnt <= (r_state == S_WAIT_CLR || r_state == S_WAIT_DONE) ? r_wcnt + 1'b1 : '0;
      r_to <= r_state == S_IDLE ? 1'b0 : (r_to || w_to);
    end
  end
  assign err_timeout = r_state == S_ACK && r_to;
`else
  assign w_to = 1'b0;
  assign err_timeout = 1'b0;
`endif
  assign busy = r_state != S_IDLE;
  assign tx_trigger = r_state == S_TRIG;
  assign ack = r_state == S_ACK ? {{(NUM_REQ-1){1'b0}}, 1'b1} << r_gid : '0;
  assign grant_id = r_gid;
  assign tx_data = r_data;
  assign tx_parity_en = r_par;
  assign tx_stop2 = r_stop2;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a simple transmitter model driving tx_sended.
module tb_uart_tx_arbiter;
  logic clk = 0, rst = 1;
  logic [3:0] req = 4'hF, req_parity = 4'b0101, req_stop2 = 4'b0011;
  logic [31:0] req_data = 32'h33323130;
  logic [3:0] ack;
  logic busy, tx_trigger, tx_parity_en, tx_stop2, err_timeout;
  logic tx_sended = 1;
  logic [1:0] grant_id;
  logic [7:0] tx_data;
  int total = 0, bad = 0;
  int drop_dly = 1, done_dly = 10;
  bit model_en = 1;
  bit saw;
  typedef struct {logic [1:0] id; logic [7:0] d; logic p; logic s;} exp_t;
  exp_t q[$];

  uart_tx_arbiter #(
`ifdef UART_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES(64),
`endif
    .NUM_REQ(4), .TRIG_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_parity(req_parity),
    .req_stop2(req_stop2), .ack(ack), .busy(busy), .grant_id(grant_id),
    .tx_trigger(tx_trigger), .tx_data(tx_data), .tx_parity_en(tx_parity_en),
    .tx_stop2(tx_stop2), .tx_sended(tx_sended), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int id);
    exp_t e;
    e.id = 2'(id);
    e.d = req_data[8*id +: 8];
    e.p = req_parity[id];
    e.s = req_stop2[id];
    q.push_back(e);
  endtask

  task automatic wait_ack(input int id, input int budget);
    for (int n = 0; n < budget && ack == 4'b0; n++) @(negedge clk);
    chk("ack", {28'b0, ack}, 32'(1 << id));
  endtask

  task automatic wait_sd(input logic v, input int budget, inout bit seen);
    for (int n = 0; n < budget && tx_sended !== v; n++) begin
      @(negedge clk);
      seen |= (ack != 4'b0);
    end
    chk("sd_wait", {31'b0, tx_sended}, {31'b0, v});
  endtask

  initial forever begin
    @(posedge tx_trigger);
    if (model_en) begin
      repeat (drop_dly) @(posedge clk);
      #1 tx_sended = 0;
      repeat (done_dly) @(posedge clk);
      #1 tx_sended = 1;
    end
  end

  initial begin
    logic prev = 0;
    int len = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_trigger && !prev) begin
        if (q.size() == 0) chk("unexp_trig", 1, 0);
        else begin
          e = q.pop_front();
          chk("frame_cfg", {20'b0, grant_id, tx_data, tx_parity_en, tx_stop2},
              {20'b0, e.id, e.d, e.p, e.s});
        end
      end
      len = tx_trigger ? len + 1 : 0;
      if (!tx_trigger && prev) chk("trig_len", len_prev(len), 4);
      prev = tx_trigger;
    end
  end

  int hi_cnt = 0;
  always @(negedge clk) hi_cnt <= tx_trigger ? hi_cnt + 1 : 0;
  function automatic int len_prev(input int unused_len);
    return hi_cnt + unused_len;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {28'b0, ack}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_outs", {19'b0, tx_trigger, grant_id, tx_data, tx_parity_en, tx_stop2, err_timeout}, 0);
    push(0);
    rst = 0;
    wait_ack(0, 100);
    req = 0;
    @(negedge clk);
    chk("ack_once", {28'b0, ack}, 0);
    // single request, exact ack latency after the done flag rises
    req_data[23:16] = 8'hA5;
    req_parity[2] = 1;
    req_stop2[2] = 0;
    done_dly = 100;
    push(2);
    req = 4'b0100;
    saw = 0;
    wait_sd(0, 50, saw);
    req_data[23:16] = 8'h00;
    wait_sd(1, 200, saw);
    chk("single_early", {31'b0, saw}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("single_gap", {28'b0, ack}, 0);
    end
    @(negedge clk);
    chk("single_ack", {28'b0, ack}, 32'h4);
    chk("hold_data", {24'b0, tx_data}, 32'hA5);
    chk("no_err", {31'b0, err_timeout}, 0);
    req = 0;
    @(negedge clk);
    chk("single_once", {28'b0, ack}, 0);
    // round robin from a fresh pointer
    rst = 1;
    @(negedge clk);
    rst = 0;
    done_dly = 10;
    foreach (q[i]) chk("q_pre_rr", 1, 0);
    for (int r = 0; r < 2; r++) begin push(0); push(1); push(3); end
    req = 4'b1011;
    for (int r = 0; r < 2; r++) begin
      wait_ack(0, 100); @(negedge clk);
      wait_ack(1, 100); @(negedge clk);
      wait_ack(3, 100);
      if (r == 1) req = 0;
      @(negedge clk);
    end
    // done flag still high from the previous frame
    drop_dly = 20;
    push(1);
    req = 4'b0010;
    saw = 0;
    wait_sd(0, 100, saw);
    chk("stale_noack", {31'b0, saw}, 0);
    wait_ack(1, 100);
    req = 0;
    drop_dly = 1;
    @(negedge clk);
    // reset in the middle of a frame
    done_dly = 50;
    push(3);
    req = 4'b1000;
    saw = 0;
    wait_sd(0, 50, saw);
    repeat (10) @(negedge clk);
    rst = 1;
    req = 0;
    @(negedge clk);
    rst = 0;
    chk("rst_mid_busy", {31'b0, busy}, 0);
    wait_sd(1, 100, saw);
    repeat (5) begin @(negedge clk); saw |= (ack != 4'b0); end
    chk("rst_mid_noack", {31'b0, saw}, 0);
    done_dly = 10;
    push(1);
    req = 4'b1010;
    wait_ack(1, 100);
    req = 0;
    @(negedge clk);
`ifdef UART_ARB_TIMEOUT_EN
    model_en = 0;
    tx_sended = 0;
    push(0);
    req = 4'b0001;
    wait_ack(0, 300);
    chk("to_err", {31'b0, err_timeout}, 1);
    req = 0;
    @(negedge clk);
    tx_sended = 1;
    model_en = 1;
    push(1);
    req = 4'b0010;
    wait_ack(1, 100);
    chk("to_next_err", {31'b0, err_timeout}, 0);
    req = 0;
    @(negedge clk);
`endif
    repeat (3) @(negedge clk);
    chk("q_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
